// File: rtl/femto_reset_pkg.sv
// femto_reset_pkg: sequencer state encoding and counter sizing
package femto_reset_pkg;
    typedef enum logic [2:0] {WAIT_LOCK, FILTER, HOLD_PERIPH, HOLD_CORE, RUN} state_t;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/femto_sync_bit.sv
// femto_sync_bit: N-stage bit synchroniser with synchronous active-low clear
module femto_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk)
        sr <= !resetn ? '0 : {sr[STAGES-2:0], d};
    assign q = sr[STAGES-1];
endmodule

// File: rtl/femto_reset_seq.sv
// femto_reset_seq: MMCM-lock driven peripheral/core reset sequencer (button debounce via FEMTO_RESET_DEBOUNCE_EN)
module femto_reset_seq
    import femto_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 1024,
`ifdef FEMTO_RESET_DEBOUNCE_EN
    parameter int DEBOUNCE_CYCLES = 65536,
`endif
    parameter int CORE_DELAY = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic pll_locked,
`ifdef FEMTO_RESET_DEBOUNCE_EN
    input  logic btn_n,
`endif
    output logic periph_resetn,
    output logic core_resetn,
    output logic ready,
    output logic lock_lost
);
    localparam int CW = cnt_width(LOCK_FILTER, HOLD_CYCLES, CORE_DELAY);
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic lk_s, btn_hold, btn_busy, lost_set;
    femto_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk(clk), .resetn(resetn), .d(pll_locked), .q(lk_s)
    );
`ifdef FEMTO_RESET_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic btn_s;
    logic [DW-1:0] dcnt;
    femto_sync_bit #(.STAGES(2)) u_btn_sync (
        .clk(clk), .resetn(resetn), .d(btn_n), .q(btn_s)
    );
    always_ff @(posedge clk)
        if (!resetn || btn_s) dcnt <= '0;
        else if (dcnt != DW'(DEBOUNCE_CYCLES)) dcnt <= dcnt + 1'b1;
    assign btn_hold = dcnt == DW'(DEBOUNCE_CYCLES);
    assign btn_busy = dcnt != '0;
`else
    assign btn_hold = 1'b0;
    assign btn_busy = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        lost_set = 1'b0;
        unique case (state)
            WAIT_LOCK:   if (lk_s && !btn_busy) state_nx = FILTER;
            FILTER:      state_nx = !lk_s ? WAIT_LOCK : cnt == CW'(LOCK_FILTER - 1) ? HOLD_PERIPH : FILTER;
            HOLD_PERIPH: if (cnt == CW'(HOLD_CYCLES - 1)) state_nx = HOLD_CORE;
            HOLD_CORE:   if (cnt == CW'(CORE_DELAY - 1)) state_nx = RUN;
            RUN:         state_nx = RUN;
            default:     state_nx = WAIT_LOCK;
        endcase
        if (btn_hold) state_nx = WAIT_LOCK;
        // lock loss outranks counter completion in the same cycle
        if (!lk_s && (state == HOLD_PERIPH || state == HOLD_CORE || state == RUN)) begin
            state_nx = WAIT_LOCK;
            lost_set = 1'b1;
        end
        cnt_nx = (state_nx != state || state == WAIT_LOCK || state == RUN) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            lock_lost     <= 1'b0;
            periph_resetn <= 1'b0;
            core_resetn   <= 1'b0;
            ready         <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            lock_lost     <= lock_lost | lost_set;
            periph_resetn <= state_nx == HOLD_CORE || state_nx == RUN;
            core_resetn   <= state_nx == RUN;
            ready         <= state_nx == RUN;
        end
    end
endmodule
